// File: rtl/demux4_dispatch_ctrl_if.sv
// Handshake bundle for demux4_dispatch_ctrl: upstream valid/ready stream, steering config,
// and the four-channel consumer side.
interface demux4_dispatch_ctrl_if #(
  parameter int DW = 8
);
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic          MODE;
  logic [1:0]    CFG_SEL;
  logic [3:0]    CH_EN;
  logic [3:0]    OUT_VALID;
  logic [3:0]    OUT_READY;
  logic [DW-1:0] OUT_DATA;
  logic [1:0]    SEL;
  logic          BUSY;

  modport master (
    output IN_VALID, IN_DATA, MODE, CFG_SEL, CH_EN, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, SEL, BUSY
  );

  modport slave (
    input  IN_VALID, IN_DATA, MODE, CFG_SEL, CH_EN, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, SEL, BUSY
  );
endinterface

// File: rtl/demux4_dispatch_ctrl.sv
// One-word buffered 1-to-4 dispatcher: round-robin or fixed steering, drives SEL and one-hot valids.
// Optional per-channel saturating delivery counters when DEMUX4_DISPATCH_CNT_EN is defined.
module demux4_dispatch_ctrl #(
  parameter int DW = 8
`ifdef DEMUX4_DISPATCH_CNT_EN
  , parameter int CW = 8
`endif
) (
  input  logic                   CLK,
  input  logic                   RST,
  demux4_dispatch_ctrl_if.slave  bus
`ifdef DEMUX4_DISPATCH_CNT_EN
  , input  logic [1:0]           CNT_IDX
  , output logic [CW-1:0]        CNT_VAL
`endif
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [1:0]    ptr_r;
  logic [1:0]    sel_r;
  logic [DW-1:0] data_r;

  logic [1:0]    tgt_s;
  logic          notarget_s;
  logic          drain_s;
  logic          in_ready_s;
  logic          capture_s;
  logic [3:0]    out_valid_s;
  logic          busy_s;

  // Scan from the highest offset down so the lowest enabled offset from ptr wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] en);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (en[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  // Target channel selection and handshake qualifiers.
  always_comb begin
    tgt_s      = 2'd0;
    notarget_s = 1'b0;
    if (bus.MODE) begin
      tgt_s      = bus.CFG_SEL;
      notarget_s = 1'b0;
    end else begin
      tgt_s      = rr_pick(ptr_r, bus.CH_EN);
      notarget_s = (bus.CH_EN == 4'b0000);
    end
    drain_s    = (state_r == FULL) && bus.OUT_READY[sel_r];
    in_ready_s = !RST && !notarget_s && ((state_r == EMPTY) || drain_s);
    capture_s  = bus.IN_VALID && in_ready_s;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a drain with a simultaneous capture stays FULL.
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY:   state_s = capture_s ? FULL : EMPTY;
      FULL:    state_s = (drain_s && !capture_s) ? EMPTY : FULL;
      default: state_s = EMPTY;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    busy_s      = (state_r == FULL);
    out_valid_s = 4'b0000;
    if (busy_s) begin
      out_valid_s = 4'b0001 << sel_r;
    end else begin
      out_valid_s = 4'b0000;
    end
  end

  // Held word, its channel, and the round-robin pointer (fixed mode leaves the pointer alone).
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_r <= {DW{1'b0}};
      sel_r  <= 2'd0;
      ptr_r  <= 2'd0;
    end else if (capture_s) begin
      data_r <= bus.IN_DATA;
      sel_r  <= tgt_s;
      if (!bus.MODE) begin
        ptr_r <= tgt_s + 2'd1;
      end
    end
  end

  assign bus.IN_READY  = in_ready_s;
  assign bus.OUT_VALID = out_valid_s;
  assign bus.OUT_DATA  = data_r;
  assign bus.SEL       = sel_r;
  assign bus.BUSY      = busy_s;

`ifdef DEMUX4_DISPATCH_CNT_EN
  logic [CW-1:0] cnt_r [4];

  // Per-channel delivery counters, saturating at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else if (drain_s && (cnt_r[sel_r] != {CW{1'b1}})) begin
      cnt_r[sel_r] <= cnt_r[sel_r] + CW'(1);
    end
  end

  assign CNT_VAL = cnt_r[CNT_IDX];
`endif

endmodule

// File: tb/tb_demux4_dispatch_ctrl.sv
// Bench for demux4_dispatch_ctrl: directed vector table, multi-cycle corner sequences,
// then random traffic against a queue-free behavioural model of the dispatcher.
module tb_demux4_dispatch_ctrl;

`ifdef DEMUX4_DISPATCH_CNT_EN
  localparam int CW = 2;
`endif

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  demux4_dispatch_ctrl_if #(.DW(8)) bus ();

`ifdef DEMUX4_DISPATCH_CNT_EN
  logic [1:0]    cnt_idx;
  logic [CW-1:0] cnt_val;
  demux4_dispatch_ctrl #(.DW(8), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .CNT_IDX(cnt_idx), .CNT_VAL(cnt_val)
  );
`else
  demux4_dispatch_ctrl #(.DW(8)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       mode;
    logic [1:0] cfg;
    logic [3:0] en;
    logic [3:0] ordy;
    logic       ir;
    logic [3:0] ov;
    logic [1:0] sel;
    logic [7:0] od;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] d,
                              input logic mode, input logic [1:0] cfg, input logic [3:0] en,
                              input logic [3:0] ordy, input logic ir, input logic [3:0] ov,
                              input logic [1:0] sel, input logic [7:0] od, input logic busy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.mode = mode; v.cfg = cfg; v.en = en; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.sel = sel; v.od = od; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [7:0] d, input logic mode,
                       input logic [1:0] cfg, input logic [3:0] en, input logic [3:0] ordy);
    RST           = rst;
    bus.IN_VALID  = iv;
    bus.IN_DATA   = d;
    bus.MODE      = mode;
    bus.CFG_SEL   = cfg;
    bus.CH_EN     = en;
    bus.OUT_READY = ordy;
  endtask

  // Drive one vector, check ready before the edge and the registered outputs after it.
  task automatic apply(input vec_t v, input string tag);
    drive(v.rst, v.iv, v.d, v.mode, v.cfg, v.en, v.ordy);
    #1;
    check({tag, "_in_ready"}, 32'(bus.IN_READY), 32'(v.ir));
    @(posedge CLK);
    #1;
    check({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'(v.ov));
    check({tag, "_sel"},       32'(bus.SEL),       32'(v.sel));
    check({tag, "_out_data"},  32'(bus.OUT_DATA),  32'(v.od));
    check({tag, "_busy"},      32'(bus.BUSY),      32'(v.busy));
  endtask

  // Reference model state
  bit m_held;
  int m_data;
  int m_sel;
  int m_ptr;
  int m_cnt[4];

  function automatic int model_target(input int p, input logic [3:0] en);
    for (int k = 0; k < 4; k++) begin
      if (en[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  initial begin
    logic       r_rst, r_iv, r_mode;
    logic [7:0] r_d;
    logic [1:0] r_cfg;
    logic [3:0] r_en, r_ordy;
    int         t;
    bit         drain, exp_ir;

    checks = 0;
    errors = 0;
`ifdef DEMUX4_DISPATCH_CNT_EN
    cnt_idx = 2'd0;
`endif
    drive(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 4'hF);
    @(posedge CLK);
    #1;

    // Reset held with IN_VALID high, then round-robin over all channels
    tbl.push_back(mk(1'b1, 1'b1, 8'h11, 1'b0, 2'd0, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h11, 1'b0, 2'd0, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hA0, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0001, 2'd0, 8'hA0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hA1, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0010, 2'd1, 8'hA1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hA2, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0100, 2'd2, 8'hA2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hA3, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 4'b1000, 2'd3, 8'hA3, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hA4, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0001, 2'd0, 8'hA4, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hA5, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0010, 2'd1, 8'hA5, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0000, 2'd1, 8'hA5, 1'b0));
    // Reset pointer, then mask 1010
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hB0, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 4'b0010, 2'd1, 8'hB0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hB1, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 4'b1000, 2'd3, 8'hB1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hB2, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 4'b0010, 2'd1, 8'hB2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hB3, 1'b0, 2'd0, 4'hA, 4'hF, 1'b1, 4'b1000, 2'd3, 8'hB3, 1'b1));
    // No enabled channel: drain completes but nothing new is accepted
    tbl.push_back(mk(1'b0, 1'b1, 8'hC0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b0, 4'b0000, 2'd3, 8'hB3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'hC0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b0, 4'b0000, 2'd3, 8'hB3, 1'b0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Fixed channel 2 stalled by OUT_READY=1011, then released with back-to-back capture
    apply(mk(1'b0, 1'b1, 8'h55, 1'b1, 2'd2, 4'hF, 4'b1011, 1'b1, 4'b0100, 2'd2, 8'h55, 1'b1), "stall_cap");
    for (int i = 0; i < 3; i++)
      apply(mk(1'b0, 1'b1, 8'h66, 1'b1, 2'd2, 4'hF, 4'b1011, 1'b0, 4'b0100, 2'd2, 8'h55, 1'b1),
            $sformatf("stall%0d", i));
    apply(mk(1'b0, 1'b1, 8'h66, 1'b1, 2'd2, 4'hF, 4'b0100, 1'b1, 4'b0100, 2'd2, 8'h66, 1'b1), "release");
    apply(mk(1'b0, 1'b0, 8'h00, 1'b1, 2'd2, 4'hF, 4'b0100, 1'b1, 4'b0000, 2'd2, 8'h66, 1'b0), "drain_last");

    // Held word on ch1 discarded by reset; next round-robin capture goes to ch0
    apply(mk(1'b0, 1'b1, 8'hD1, 1'b0, 2'd0, 4'b0010, 4'h0, 1'b1, 4'b0010, 2'd1, 8'hD1, 1'b1), "rst_fill");
    apply(mk(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 4'b0010, 2'd1, 8'hD1, 1'b1), "rst_hold");
    apply(mk(1'b1, 1'b1, 8'hD2, 1'b0, 2'd0, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0), "rst_mid");
    apply(mk(1'b0, 1'b1, 8'hD3, 1'b0, 2'd0, 4'hF, 4'h0, 1'b1, 4'b0001, 2'd0, 8'hD3, 1'b1), "rst_next");
    apply(mk(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 8'hD3, 1'b0), "rst_drain");

`ifdef DEMUX4_DISPATCH_CNT_EN
    // Five drains on ch3 saturate a 2-bit counter
    apply(mk(1'b1, 1'b0, 8'h00, 1'b1, 2'd3, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0), "cnt_rst");
    for (int i = 0; i < 5; i++)
      apply(mk(1'b0, 1'b1, 8'hE0 + 8'(i), 1'b1, 2'd3, 4'hF, 4'hF, 1'b1, 4'b1000, 2'd3,
               8'hE0 + 8'(i), 1'b1), $sformatf("cnt_w%0d", i));
    apply(mk(1'b0, 1'b0, 8'h00, 1'b1, 2'd3, 4'hF, 4'hF, 1'b1, 4'b0000, 2'd3, 8'hE4, 1'b0), "cnt_idle");
    cnt_idx = 2'd3;
    #1;
    check("cnt_ch3_sat", 32'(cnt_val), 32'd3);
    cnt_idx = 2'd0;
    #1;
    check("cnt_ch0", 32'(cnt_val), 32'd0);
`endif

    // Random traffic against the behavioural model, starting from reset
    drive(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 4'hF);
    @(posedge CLK);
    #1;
    m_held = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;

    for (int n = 0; n < 600; n++) begin
      r_rst  = ($urandom_range(0, 49) == 0);
      r_iv   = ($urandom_range(0, 9) < 7);
      r_d    = 8'($urandom);
      r_mode = ($urandom_range(0, 3) == 0);
      r_cfg  = 2'($urandom);
      r_en   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      r_ordy = 4'($urandom);
      drive(r_rst, r_iv, r_d, r_mode, r_cfg, r_en, r_ordy);
`ifdef DEMUX4_DISPATCH_CNT_EN
      cnt_idx = 2'($urandom);
`endif
      #1;
      t      = r_mode ? int'(r_cfg) : model_target(m_ptr, r_en);
      drain  = m_held && r_ordy[m_sel];
      exp_ir = !r_rst && (t >= 0) && (!m_held || drain);
      check($sformatf("rnd%0d_in_ready", n), 32'(bus.IN_READY), 32'(exp_ir));
`ifdef DEMUX4_DISPATCH_CNT_EN
      check($sformatf("rnd%0d_cnt", n), 32'(cnt_val), 32'(m_cnt[cnt_idx]));
`endif
      @(posedge CLK);
      if (r_rst) begin
        m_held = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      end else begin
        if (drain && m_cnt[m_sel] < (1 << CW_MODEL()) - 1) m_cnt[m_sel]++;
        if (r_iv && exp_ir) begin
          m_held = 1;
          m_data = int'(r_d);
          m_sel  = t;
          if (!r_mode) m_ptr = (t + 1) % 4;
        end else if (drain) begin
          m_held = 0;
        end
      end
      #1;
      check($sformatf("rnd%0d_out_valid", n), 32'(bus.OUT_VALID), m_held ? (32'd1 << m_sel) : 32'd0);
      check($sformatf("rnd%0d_sel", n),       32'(bus.SEL),       32'(m_sel));
      check($sformatf("rnd%0d_out_data", n),  32'(bus.OUT_DATA),  32'(m_data));
      check($sformatf("rnd%0d_busy", n),      32'(bus.BUSY),      32'(m_held));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic int CW_MODEL();
`ifdef DEMUX4_DISPATCH_CNT_EN
    return CW;
`else
    return 8;
`endif
  endfunction

endmodule
